popcount_sequencer: RTL and testbench
=====================================

# popcount_sequencer

Multi-cycle population counter for words wider than one `summator` instance. Accepts a `TOTAL_W`-bit word over a valid/ready handshake and slices it into `CHUNKS` slices of `DATA_W` bits. It drives one internal `summator` with one slice per cycle and accumulates the partial counts, then presents the total count on a valid/ready output. It is the controller that time-shares a single `summator` across a wide operand, trading latency for area.

## Interface

Parameters:
- `DATA_W`, 10: slice width; width of the internal `summator`.
- `CHUNKS`, 4: number of slices per word; must be ≥ 1.
- `POS_W`, `$clog2(DATA_W+1)`: width of the `summator` result.
- Derived (localparam) `TOTAL_W = DATA_W*CHUNKS`.
- Derived (localparam) `SUM_W = $clog2(TOTAL_W+1)`.
- Derived (localparam) `IDX_W = (CHUNKS>1) ? $clog2(CHUNKS) : 1`.

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: block can accept a word.
- `in_data`, in, `TOTAL_W`: word to count.
- `out_valid`, out, 1: `out_sum` is valid.
- `out_ready`, in, 1: consumer accepts `out_sum`.
- `out_sum`, out, `SUM_W`: number of set bits in the accepted word.
- `busy`, out, 1: high in RUN or DONE.

## Operation

State machine `{IDLE, RUN, DONE}`, reset state IDLE.

- IDLE:
  - `in_ready`=1.
  - On `in_valid` (accept edge): capture `in_data` into a shadow register, clear `idx` to 0 and `acc` to 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - The `summator` input is `shadow[idx*DATA_W +: DATA_W]`. Slice 0 (LSBs) goes first.
  - Each cycle: `acc <= acc + zext(sum)` and `idx <= idx + 1`.
  - When `idx == CHUNKS-1`: load `out_sum <= acc + zext(sum)` and go to DONE.
  - `in_valid` is ignored in RUN.
- DONE:
  - `out_valid`=1.
  - `out_sum` is held stable.
  - On `out_ready`: go to IDLE.
  - `in_ready` stays 0 in DONE. There is no overlap of the next accept with the output handshake.

Arithmetic and widths:
- All additions are performed at `SUM_W` bits, with `sum` zero-extended.
- Overflow is impossible by construction, since the maximum is `TOTAL_W`.
- `idx` never exceeds `CHUNKS-1`; no wrap is observable.

`CHUNKS`=1:
- RUN lasts exactly one cycle.
- `out_sum` equals the `summator` result of the whole word.

Outputs are decoded from state only. `out_sum` is a register. Nothing combinational runs from `in_*` to `out_*`.

Reset:
- `rst` high on any edge forces IDLE and sets `out_valid`=0, `out_sum`=0, `acc`=0, `idx`=0, `shadow`=0, `busy`=0.
- `in_ready`=0 while `rst` is high, and 1 in the first cycle after `rst` drops.
- Reset mid-RUN or mid-DONE discards the word. No `out_valid` is produced for it.

## Timing

- The accept edge is the edge where `in_valid && in_ready`. Call it edge E.
- RUN occupies the cycles after edges E … E+CHUNKS-1.
- `out_valid` rises after edge E+CHUNKS. Latency is `CHUNKS` cycles from accept to result.
- DONE lasts at least 1 cycle. It exits on the edge where `out_valid && out_ready`.
- `in_ready` re-asserts on the cycle after that edge.
- Maximum throughput is one word per `CHUNKS+2` cycles when `out_ready` is held at 1.
- `busy` = (state != IDLE), registered with state.

## Test plan

1. **All ones, default parameters.** `DATA_W`=10, `CHUNKS`=4, `in_data` = 40'hFF_FFFF_FFFF, `out_ready`=1 → `out_valid` rises 4 cycles after accept, with `out_sum` = 40 (6'b101000).
2. **Zero and sparse words.**
   - `in_data`=0 → `out_sum`=0.
   - `in_data` = 40'h80_0000_0001 → `out_sum`=2, which checks that the first and last slices are both counted.
3. **Output backpressure.**
   - Hold `out_ready`=0 for 5 cycles in DONE → `out_valid`, `out_sum` and `busy` are stable, and `in_ready`=0.
   - Raise `out_ready` → IDLE on the next cycle, with `in_ready`=1.
4. **Input ignored while busy.** Keep `in_valid`=1 continuously with a new `in_data` each cycle → the block takes only the first word, with `in_ready`=0 in RUN and DONE. Use `out_ready`=1 and check each result against a reference popcount. The next accept occurs `CHUNKS+2` cycles after the previous one.
5. **Reset mid-operation.** Assert `rst` for 1 cycle at RUN with `idx`=2 → the next cycle has IDLE, `out_valid`=0, `out_sum`=0 and `in_ready`=1. A new word of all ones then yields 40.
6. **Single-slice and random regression.**
   - `CHUNKS`=1, `DATA_W`=10, `in_data` = 10'b1011001110 → `out_sum`=6, 1 cycle after accept.
   - Random words at `CHUNKS`=3, `DATA_W`=7, matched against `$countones`.

Source files
------------

// File: rtl/popcount_sequencer.sv
// Multi-cycle population counter: slices a wide word into CHUNKS pieces and
// time-shares one summator across them, accumulating the partial counts.

module summator #(
  parameter int DATA_W = 10,
  parameter int POS_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  output logic [POS_W-1:0]  sum
);

  always_comb begin
    // NOTE: blocking assignments in combinational logic let the loop chain the running total.
    sum = '0;
    for (int i = 0; i < DATA_W; i++) begin
      sum = sum + POS_W'(data[i]);
    end
  end

endmodule

module popcount_sequencer #(
  parameter int DATA_W = 10,
  parameter int CHUNKS = 4,
  parameter int POS_W  = $clog2(DATA_W + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DATA_W*CHUNKS-1:0]                in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [$clog2(DATA_W*CHUNKS+1)-1:0]      out_sum,
  output logic                                    busy
);

  localparam int TOTAL_W = DATA_W * CHUNKS;
  localparam int SUM_W   = $clog2(TOTAL_W + 1);
  localparam int IDX_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [TOTAL_W-1:0] shadow;
  logic [IDX_W-1:0]   idx;
  logic [SUM_W-1:0]   acc;
  logic [DATA_W-1:0]  slice;
  logic [POS_W-1:0]   slice_sum;
  logic [SUM_W-1:0]   next_acc;

  assign slice    = shadow[int'(idx)*DATA_W +: DATA_W];
  assign next_acc = acc + SUM_W'(slice_sum);

  // Gated by rst so the block never advertises readiness while being reset.
  assign in_ready = (state == IDLE) && !rst;

  summator #(
    .DATA_W (DATA_W),
    .POS_W  (POS_W)
  ) u_summator (
    .data (slice),
    .sum  (slice_sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      idx       <= '0;
      acc       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shadow <= in_data;
            idx    <= '0;
            acc    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= next_acc;
          if (idx == LAST_IDX) begin
            out_sum   <= next_acc;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Scoreboard bench for popcount_sequencer: default, single-slice and 7x3 instances.

module tb_popcount_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance: DATA_W=10, CHUNKS=4
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [39:0] in_data;
  logic [5:0]  out_sum;

  // single-slice instance: DATA_W=10, CHUNKS=1
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [9:0] s_in_data;
  logic [3:0] s_out_sum;

  // random-regression instance: DATA_W=7, CHUNKS=3
  logic        r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_busy;
  logic [20:0] r_in_data;
  logic [4:0]  r_out_sum;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  popcount_sequencer #(.DATA_W(10), .CHUNKS(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
  );

  popcount_sequencer #(.DATA_W(10), .CHUNKS(1)) u_single (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum), .busy(s_busy)
  );

  popcount_sequencer #(.DATA_W(7), .CHUNKS(3)) u_rand (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_sum(r_out_sum), .busy(r_busy)
  );

  task automatic step();
    @(negedge clk);
  endtask

  // Drive one word into the default instance and wait for its result.
  task automatic send_word(input logic [39:0] d, output int lat);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready: in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back($countones(d));
    step();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      step();
      lat++;
    end
  endtask

  // Pop and compare a result currently presented with out_ready=1, then check the return to IDLE.
  task automatic collect(input string name);
    int e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: result %0d with empty scoreboard", name, out_sum);
    end else begin
      e = exp_q.pop_front();
      if (out_sum !== 6'(e)) begin
        bad++;
        $display("FAIL %s: out_sum=%0d want %0d", name, out_sum, e);
      end
    end
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: in_ready=%b out_valid=%b busy=%b want 1 0 0", name, in_ready, out_valid, busy);
    end
  endtask

  task automatic check_lat(input string name, input int lat, input int want);
    total++;
    if (lat !== want) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 6'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_sum=%0d busy=%b want 0 0 0 0",
               in_ready, out_valid, out_sum, busy);
    end
    total++;
    if (s_out_valid !== 1'b0 || r_out_valid !== 1'b0 || s_in_ready !== 1'b0 || r_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_aux: s_out_valid=%b r_out_valid=%b s_in_ready=%b r_in_ready=%b want 0 0 0 0",
               s_out_valid, r_out_valid, s_in_ready, r_in_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_all_ones();
    int lat;
    out_ready = 1'b1;
    send_word(40'hFF_FFFF_FFFF, lat);
    check_lat("all_ones", lat, 4);
    collect("all_ones");
  endtask

  task automatic test_sparse();
    int lat;
    send_word(40'h0, lat);
    check_lat("zero", lat, 4);
    collect("zero");
    send_word(40'h80_0000_0001, lat);
    check_lat("ends", lat, 4);
    collect("ends");
    send_word(40'h00_0300_0C00, lat);
    check_lat("mid", lat, 4);
    collect("mid");
  endtask

  task automatic test_backpressure();
    int lat;
    logic [5:0] held;
    out_ready = 1'b0;
    send_word(40'h5A_A5F0_0F3C, lat);
    check_lat("bp", lat, 4);
    held = out_sum;
    total++;
    if (held !== 6'($countones(40'h5A_A5F0_0F3C))) begin
      bad++;
      $display("FAIL bp_sum: out_sum=%0d want %0d", held, $countones(40'h5A_A5F0_0F3C));
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_sum !== held || busy !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: cycle %0d out_valid=%b out_sum=%0d busy=%b in_ready=%b want 1 %0d 1 0",
                 i, out_valid, out_sum, busy, in_ready, held);
      end
    end
    out_ready = 1'b1;
    collect("bp_release");
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int e;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) begin
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (out_sum !== 6'(e)) begin
          bad++;
          $display("FAIL b2b_sum: out_sum=%0d want %0d", out_sum, e);
        end
      end
      if (busy === 1'b1) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b_ready: cycle %0d in_ready=%b want 0 while busy", i, in_ready);
        end
      end
      in_valid = 1'b1;
      in_data  = {8'($urandom()), $urandom()};
      if (in_ready === 1'b1) begin
        exp_q.push_back($countones(in_data));
        acc_cyc.push_back(i);
      end
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      if (out_valid === 1'b1) begin
        total++;
        e = exp_q.pop_front();
        if (out_sum !== 6'(e)) begin
          bad++;
          $display("FAIL b2b_drain: out_sum=%0d want %0d", out_sum, e);
        end
      end
      step();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_timeout: %0d results outstanding want 0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (acc_cyc.size() < 6) begin
      bad++;
      $display("FAIL b2b_count: accepts=%0d want at least 6", acc_cyc.size());
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      total++;
      if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
        bad++;
        $display("FAIL b2b_interval: got %0d want 6", acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    in_valid = 1'b1;
    in_data  = 40'hAB_CDEF_1234;
    step();
    in_valid = 1'b0;
    step();
    step();
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_run: busy=%b out_valid=%b want 1 0", busy, out_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 6'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b out_sum=%0d busy=%b want 1 0 0 0",
               in_ready, out_valid, out_sum, busy);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_discard: cycle %0d out_valid=%b want 0", i, out_valid);
      end
    end
    send_word(40'hFF_FFFF_FFFF, lat);
    check_lat("mid_after", lat, 4);
    collect("mid_after");
  endtask

  task automatic test_single_slice();
    int lat;
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_in_data   = 10'b1011001110;
    step();
    s_in_valid = 1'b0;
    lat = 0;
    while (s_out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check_lat("single", lat, 1);
    total++;
    if (s_out_sum !== 4'd6) begin
      bad++;
      $display("FAIL single_sum: out_sum=%0d want 6", s_out_sum);
    end
    step();
    total++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: in_ready=%b out_valid=%b want 1 0", s_in_ready, s_out_valid);
    end
  endtask

  task automatic test_random();
    int lat;
    int e;
    r_out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      r_in_valid = 1'b1;
      r_in_data  = (n == 0) ? 21'h1F_FFFF : 21'($urandom());
      exp_q.push_back($countones(r_in_data));
      step();
      r_in_valid = 1'b0;
      lat = 0;
      while (r_out_valid !== 1'b1 && lat < 30) begin
        step();
        lat++;
      end
      check_lat("rand", lat, 3);
      e = exp_q.pop_front();
      total++;
      if (r_out_sum !== 5'(e)) begin
        bad++;
        $display("FAIL rand_sum: word %0d out_sum=%0d want %0d", n, r_out_sum, e);
      end
      step();
    end
  endtask

  initial begin
    in_valid = 1'b0;  in_data = '0;    out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    r_in_valid = 1'b0; r_in_data = '0; r_out_ready = 1'b1;
    test_reset();
    test_all_ones();
    test_sparse();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_single_slice();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
